// File: rtl/maint_iseq_dispatcher.sv
// maint_iseq_dispatcher: consumer end of the maintenance instruction interface.
// Arbitrates between host and maintenance iseqs at iseq boundaries, executes WAIT
// and SET_BUSDIR locally and forwards DDR commands to the PHY, one per cycle.
//   clk, rst                 : clock, synchronous active-high reset
//   host_instr/valid/ready   : host iseq stream (ready = consumed this cycle)
//   maint_instr_en/instr/ack : maintenance handler stream (ack = consumed)
//   periodic_read_lock       : from handler; pr_rd_ack pulses on host READs under lock
//   cur_bus_dir              : registered bus direction
//   phy_ready, ddr_cmd/valid : PHY command path
//   maint_stall_cnt          : only when DISPATCH_STALL_CNT_EN is defined
// Instruction: [31:28] opcode, [27:0] payload. DDR payload layout:
//   [18:0] bank/address, [19] WE, [20] CAS, [21] RAS, [22 +: CS_WIDTH] CS.
module maint_iseq_dispatcher #(
  parameter int CS_WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] host_instr,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        maint_instr_en,
  input  logic [31:0] maint_instr,
  output logic        maint_ack,
  input  logic        periodic_read_lock,
  output logic        pr_rd_ack,
  output logic [1:0]  cur_bus_dir,
  input  logic        phy_ready,
  output logic [27:0] ddr_cmd,
  output logic        ddr_cmd_valid
`ifdef DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0] maint_stall_cnt
`endif
);

  localparam logic [3:0] OP_END_ISEQ   = 4'b0000;
  localparam logic [3:0] OP_SET_BUSDIR = 4'b0001;
  localparam logic [3:0] OP_WAIT       = 4'b0100;
  localparam logic [3:0] OP_DDR_INSTR  = 4'b1000;
  localparam logic [1:0] BUS_DIR_READ  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_HOST, S_MAINT, S_MAINT_END, S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic        ret_maint;   // WAIT return target: 1 = MAINT, 0 = HOST
  logic [27:0] wait_cnt;

  logic [31:0] sel_instr;
  logic        sel_vld;
  logic [3:0]  op;
  logic [27:0] payload;
  logic        active, is_ddr, is_wait, is_busdir, is_end, wait_long, is_read;

  // Only the granted source is looked at; reset suppresses all consumption.
  assign sel_instr = (state == S_HOST) ? host_instr : maint_instr;
  assign sel_vld   = ((state == S_HOST)  && host_valid) ||
                     ((state == S_MAINT) && maint_instr_en);
  assign active    = sel_vld && !rst;
  assign op        = sel_instr[31:28];
  assign payload   = sel_instr[27:0];
  assign is_ddr    = (op == OP_DDR_INSTR);
  assign is_wait   = (op == OP_WAIT);
  assign is_busdir = (op == OP_SET_BUSDIR);
  assign is_end    = (op == OP_END_ISEQ);
  assign wait_long = (payload > 28'd1);
  // READ: CS low, RAS=1, CAS=0, WE=1 (active-low command strobes)
  assign is_read   = (payload[22 +: CS_WIDTH] == '0) && payload[21] &&
                     !payload[20] && payload[19];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (maint_instr_en)  state_nxt = S_MAINT;
        else if (host_valid) state_nxt = S_HOST;
      end
      S_HOST, S_MAINT: begin
        if (active) begin
          if (is_end)                    state_nxt = (state == S_HOST) ? S_IDLE : S_MAINT_END;
          else if (is_wait && wait_long) state_nxt = S_WAIT;
        end
      end
      S_MAINT_END: state_nxt = S_IDLE;
      S_WAIT: begin
        if (wait_cnt == 28'd1) state_nxt = ret_maint ? S_MAINT : S_HOST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic. A maint END_ISEQ is deliberately not acked: the handler
  // keeps presenting it through MAINT_END and withdraws it on its own.
  always_comb begin
    host_ready    = 1'b0;
    maint_ack     = 1'b0;
    ddr_cmd_valid = 1'b0;
    ddr_cmd       = '0;
    pr_rd_ack     = 1'b0;
    if (active) begin
      ddr_cmd_valid = is_ddr && phy_ready;
      if (ddr_cmd_valid) ddr_cmd = payload;
      if (state == S_HOST) begin
        host_ready = is_ddr ? phy_ready : 1'b1;
        pr_rd_ack  = ddr_cmd_valid && is_read && periodic_read_lock;
      end else begin
        maint_ack  = is_ddr ? phy_ready : !is_end;
      end
    end
  end

  // WAIT counter, return target and bus direction
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      ret_maint   <= 1'b0;
      cur_bus_dir <= BUS_DIR_READ;
    end else begin
      if (active && is_wait && wait_long) begin
        wait_cnt  <= payload - 28'd1;
        ret_maint <= (state == S_MAINT);
      end else if (state == S_WAIT) begin
        wait_cnt  <= wait_cnt - 28'd1;
      end
      if (active && is_busdir) cur_bus_dir <= payload[1:0];
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  // Cycles the handler is kept waiting behind a host iseq, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      maint_stall_cnt <= '0;
    end else if (maint_instr_en && (state == S_HOST || (state == S_WAIT && !ret_maint)) &&
                 (maint_stall_cnt != 32'hFFFF_FFFF)) begin
      maint_stall_cnt <= maint_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
